// File: rtl/kgp_pkg.sv
// Shared constants for the KGPRISC branch path: word width and setflag codes.
package kgp_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_U    = 3'd1;
  localparam logic [2:0] BR_LTZ  = 3'd2;
  localparam logic [2:0] BR_Z    = 3'd3;
  localparam logic [2:0] BR_NZ   = 3'd4;
  localparam logic [2:0] BR_CY   = 3'd5;
  localparam logic [2:0] BR_NCY  = 3'd6;
  localparam logic [2:0] BR_L    = 3'd7;

endpackage

// File: rtl/flag_cond.sv
// Combinational branch-condition decode from ALU result, carry-out and setflag.
module flag_cond
  import kgp_pkg::*;
(
  input  logic [WORD_W-1:0] sum,
  input  logic              carry,
  input  logic [2:0]        setflag,
  output logic              flag,
  output logic              zf,
  output logic              sf,
  output logic              cf
);

  assign zf = (sum == '0);
  assign sf = sum[WORD_W-1];
  assign cf = carry;

  // No X-masking: an unknown on the selected status bit flows straight to flag.
  always_comb begin
    flag = 1'b0;
    case (setflag)
      BR_NONE: flag = 1'b0;
      BR_U:    flag = 1'b1;
      BR_LTZ:  flag = sf;
      BR_Z:    flag = zf;
      BR_NZ:   flag = ~zf;
      BR_CY:   flag = cf;
      BR_NCY:  flag = ~cf;
      BR_L:    flag = 1'b1;
      default: flag = 1'bx;
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// Branch-flag unit: live combinational decision plus registered decision/status copies.
module branch_flag_unit
  import kgp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] sum,
  input  logic              carry,
  input  logic [2:0]        setflag,
  output logic              flag,
  output logic              flag_q,
  output logic [2:0]        status
);

  logic zf;
  logic sf;
  logic cf;

  flag_cond u_flag_cond (
    .sum     (sum),
    .carry   (carry),
    .setflag (setflag),
    .flag    (flag),
    .zf      (zf),
    .sf      (sf),
    .cf      (cf)
  );

  // status is packed {cf, sf, zf}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      status <= 3'b000;
    end else begin
      flag_q <= flag;
      status <= {cf, sf, zf};
    end
  end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: directed vectors plus a per-cycle model compare.
module tb_branch_flag_unit;
  import kgp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sum;
  logic        carry;
  logic [2:0]  setflag;
  logic        flag;
  logic        flag_q;
  logic [2:0]  status;

  int checks = 0;
  int errors = 0;

  logic       exp_q;
  logic [2:0] exp_st;
  bit         run_cmp = 1'b0;

  branch_flag_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sum     (sum),
    .carry   (carry),
    .setflag (setflag),
    .flag    (flag),
    .flag_q  (flag_q),
    .status  (status)
  );

  always #5 clk = ~clk;

  // Branch decision straight from the condition table, using signed arithmetic.
  function automatic logic model_flag(logic [31:0] s, logic c, logic [2:0] sel);
    int signed sv;
    sv = $signed(s);
    case (sel)
      3'd0:       return 1'b0;
      3'd1, 3'd7: return 1'b1;
      3'd2:       return sv < 0;
      3'd3:       return s == 32'd0;
      3'd4:       return s != 32'd0;
      3'd5:       return c;
      default:    return !c;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected registered outputs: snapshot of pre-edge inputs, cleared by reset at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q  <= 1'b0;
      exp_st <= 3'b000;
    end else begin
      exp_q  <= model_flag(sum, carry, setflag);
      exp_st <= {carry, ($signed(sum) < 0) ? 1'b1 : 1'b0, (sum == 32'd0) ? 1'b1 : 1'b0};
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_flag", {31'd0, flag}, {31'd0, model_flag(sum, carry, setflag)});
      chk("cmp_flag_q", {31'd0, flag_q}, {31'd0, exp_q});
      chk("cmp_status", {29'd0, status}, {29'd0, exp_st});
    end
  end

  task automatic vec(input string name, input logic [31:0] s, input logic c,
                     input logic [2:0] sel, input logic exp);
    @(posedge clk);
    #2;
    sum = s; carry = c; setflag = sel;
    #1;
    chk(name, {31'd0, flag}, {31'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    sum = 32'd0; carry = 1'b0; setflag = BR_U;
    #1;
    chk("rst_flag_br", {31'd0, flag}, 32'd1);
    chk("rst_flag_q", {31'd0, flag_q}, 32'd0);
    chk("rst_status", {29'd0, status}, 32'd0);
    run_cmp = 1'b1;
    sum = 32'hFFFF_FFFF; carry = 1'b1; setflag = BR_LTZ;
    #1;
    chk("rst_flag_follows", {31'd0, flag}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_flag_q", {31'd0, flag_q}, 32'd0);
    chk("rst_hold_status", {29'd0, status}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    vec("br_sum0",       32'd0,         1'b0, BR_U,    1'b1);
    vec("ltz_m1",        32'hFFFF_FFFF, 1'b0, BR_LTZ,  1'b1);
    vec("ltz_p1",        32'd1,         1'b0, BR_LTZ,  1'b0);
    vec("bz_0",          32'd0,         1'b0, BR_Z,    1'b1);
    vec("bz_1",          32'd1,         1'b0, BR_Z,    1'b0);
    vec("bnz_1",         32'd1,         1'b0, BR_NZ,   1'b1);
    vec("bnz_0",         32'd0,         1'b0, BR_NZ,   1'b0);
    vec("bcy_c0",        32'd5,         1'b0, BR_CY,   1'b0);
    vec("bcy_c1",        32'd5,         1'b1, BR_CY,   1'b1);
    vec("bncy_c1",       32'd0,         1'b1, BR_NCY,  1'b0);
    vec("bncy_c0",       32'd0,         1'b0, BR_NCY,  1'b1);
    vec("none_a",        32'd0,         1'b1, BR_NONE, 1'b0);
    vec("none_b",        32'hFFFF_FFFF, 1'b0, BR_NONE, 1'b0);
    vec("bl",            32'd0,         1'b1, BR_L,    1'b1);
    vec("ltz_min",       32'h8000_0000, 1'b0, BR_LTZ,  1'b1);
    vec("ltz_max",       32'h7FFF_FFFF, 1'b0, BR_LTZ,  1'b0);
    vec("bz_min",        32'h8000_0000, 1'b0, BR_Z,    1'b0);

    vec("reg_setup",     32'hFFFF_FFFF, 1'b1, BR_LTZ,  1'b1);
    @(posedge clk);
    #1;
    chk("reg_flag_q", {31'd0, flag_q}, 32'd1);
    chk("reg_status", {29'd0, status}, 32'b110);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flag_q", {31'd0, flag_q}, 32'd0);
    chk("mid_rst_status", {29'd0, status}, 32'd0);
    setflag = BR_NZ; sum = 32'd0;
    #1;
    chk("mid_rst_flag", {31'd0, flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vec("post_bz",       32'd0,         1'b0, BR_Z,    1'b1);
    vec("post_bcy",      32'h1234_5678, 1'b1, BR_CY,   1'b1);
    @(posedge clk);
    #1;
    chk("post_status", {29'd0, status}, 32'b100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
# branch_flag_unit

Branch-condition evaluator for the KGPRISC datapath. From the ALU result `sum`, the ALU carry-out and a 3-bit branch-condition code `setflag` decoded from the instruction, it drives `flag` combinationally, so the PC mux can take the branch in the same cycle. It also keeps registered copies of the decision and of the ALU status bits for later pipeline stages and debug.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  system clock; registers update on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sum`  in  32  ALU result, interpreted as two's-complement signed.
- `carry`  in  1  ALU carry-out for the same operation.
- `setflag`  in  3  branch-condition select.
- `flag`  out  1  combinational branch-taken decision.
- `flag_q`  out  1  `flag` registered on `clk`.
- `status`  out  3  registered {cf, sf, zf}: carry, `sum[31]`, (`sum`==0).

## Operation
- zf = (`sum` == 32'd0); sf = `sum[31]`; cf = `carry`.
- `setflag` decode for `flag`:
  - 000: none, 0
  - 001: br, unconditional, 1
  - 010: bltz, sf
  - 011: bz, zf
  - 100: bnz, !zf
  - 101: bcy, cf
  - 110: bncy, !cf
  - 111: bl (call), unconditional, 1
- Codes 000/001/111 ignore `sum` and `carry`.
- `flag` is purely combinational. It has no dependence on `clk` or `rst_n` and is valid even while reset is asserted.
- Zero test covers all 32 bits. 32'h8000_0000 is negative and nonzero.
- Inputs are never X-masked. Any X on a selected input propagates to `flag`.

## Timing
- `flag`: zero-cycle latency, settles within one combinational delay of any input change.
- `flag_q` and `status` capture `flag` and {cf, sf, zf} every rising `clk` edge. There is no enable; latency is 1 cycle.
- `rst_n` low forces `flag_q`=0 and `status`=3'b000 immediately, without waiting for `clk`.
- On release of `rst_n`, the first rising edge loads live values.
- If reset is asserted mid-operation, the registered outputs clear at once while `flag` keeps tracking its inputs.
- If an input changes on the same edge as capture, the pre-edge value is stored.

## Structure
- Shared package `kgp_pkg`:
  - setflag code constants `BR_NONE`=0, `BR_U`=1, `BR_LTZ`=2, `BR_Z`=3, `BR_NZ`=4, `BR_CY`=5, `BR_NCY`=6, `BR_L`=7.
  - `WORD_W`=32.
- Natural split:
  - one combinational sub-module `flag_cond`: `sum`, `carry`, `setflag` in; `flag`, zf/sf/cf out.
  - a top wrapper holding the 4-bit async-reset register.

## Test plan
- Decode sweep:
  - `setflag`=001, `sum`=0 -> `flag`=1
  - `setflag`=010: `sum`=-1 -> 1; `sum`=1 -> 0
- Zero tests:
  - `setflag`=011: `sum`=0 -> 1; `sum`=1 -> 0
  - `setflag`=100: `sum`=1 -> 1; `sum`=0 -> 0
- Carry tests:
  - `setflag`=101: carry=0 -> 0; carry=1 -> 1
  - `setflag`=110: carry=1 -> 0; carry=0 -> 1
- `setflag`=000, any `sum`/`carry` -> 0. `setflag`=111, `sum`=0, carry=1 -> 1.
- Boundaries with `setflag`=010:
  - `sum`=32'h8000_0000 -> 1
  - `sum`=32'h7FFF_FFFF -> 0
  - `sum`=32'h8000_0000 under 011 -> 0
- Registers:
  - hold `rst_n`=0 -> `flag_q`=0, `status`=000 while `flag` still follows inputs.
  - release, apply `sum`=-1, carry=1, `setflag`=010, clock -> `flag_q`=1, `status`=3'b110.
  - assert `rst_n` between edges -> immediate clear.
